encoder_conditioner: RTL and testbench

Front-end for the motor-speed path. It takes the raw, asynchronous quadrature encoder channels A and B and synchronizes and debounces them. It then decodes them into clean single-cycle strobes, a direction flag and a signed position count, all in the `clock` domain. `pulse_out` is the synchronous per-revolution-edge pulse consumed directly by the downstream tachometer in place of any raw encoder signal.

---
 rtl/encoder_conditioner.sv | 122 ++++++++++++
 tb/tb_encoder_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_conditioner.sv
// rtl/encoder_conditioner.sv - quadrature encoder synchronizer, debouncer and decoder
// Produces registered step/pulse strobes, direction, wrapping position and sticky error.
module encoder_conditioner #(
    parameter int DEBOUNCE_CLOCKS = 16,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clock,
    input  logic                   system_reset,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   error_clear,
    output logic                   pulse_out,
    output logic                   step,
    output logic                   direction,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   quad_error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CLOCKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLOCKS - 1);

    // Channel vectors are packed as {A, B}
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            filt_q, filt_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            prev_q;

    logic                   step_q, step_d;
    logic                   pulse_q, pulse_d;
    logic                   dir_q, dir_d;
    logic [COUNT_WIDTH-1:0] pos_q, pos_d;
    logic                   err_q, err_d;

    logic fwd, rev, illegal;

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
        end
    end

    // A channel flips only after DEBOUNCE_CLOCKS consecutive cycles of disagreement
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] != filt_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    filt_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_q, filt_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
            default: ;
        endcase
        illegal = ((prev_q ^ filt_q) == 2'b11);
    end

    always_comb begin
        step_d  = fwd | rev;
        pulse_d = ~prev_q[1] & filt_q[1];
        dir_d   = dir_q;
        pos_d   = pos_q;
        if (fwd) begin
            dir_d = 1'b1;
            pos_d = pos_q + COUNT_WIDTH'(1);
        end else if (rev) begin
            dir_d = 1'b0;
            pos_d = pos_q - COUNT_WIDTH'(1);
        end
        // An illegal transition in the same cycle as error_clear keeps the flag set
        if (illegal) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            filt_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            step_q  <= 1'b0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            prev_q  <= filt_q;
            step_q  <= step_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign step       = step_q;
    assign direction  = dir_q;
    assign position   = pos_q;
    assign quad_error = err_q;

endmodule

// File: tb/tb_encoder_conditioner.sv
// tb/tb_encoder_conditioner.sv - scoreboard bench for encoder_conditioner
module tb_encoder_conditioner;

    localparam int DB = 4;
    localparam int LAT = DB + 3;

    logic        clock = 1'b0;
    logic        system_reset = 1'b0;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        error_clear = 1'b0;
    logic        pulse_out;
    logic        step;
    logic        direction;
    logic [31:0] position;
    logic        quad_error;

    encoder_conditioner #(.DEBOUNCE_CLOCKS(DB), .COUNT_WIDTH(32)) dut (
        .clock        (clock),
        .system_reset (system_reset),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .error_clear  (error_clear),
        .pulse_out    (pulse_out),
        .step         (step),
        .direction    (direction),
        .position     (position),
        .quad_error   (quad_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic        step;
        logic        pulse;
        logic        dir;
        logic [31:0] pos;
        logic        qe;
    } event_t;

    event_t exp_q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  m_prev = 2'b00;
    logic [31:0] m_pos = '0;
    logic        m_dir = 1'b0;
    logic        m_qe = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Updates the model for a filtered transition and queues the expected strobe
    task automatic push_event(input int at, input logic [1:0] ab);
        event_t e;
        logic f, r, bad;
        f   = (ab == fwd_next(m_prev));
        r   = (m_prev == fwd_next(ab));
        bad = ((ab ^ m_prev) == 2'b11);
        if (f) begin m_dir = 1'b1; m_pos = m_pos + 1; end
        if (r) begin m_dir = 1'b0; m_pos = m_pos - 1; end
        if (bad) m_qe = 1'b1;
        e.cyc = at; e.step = f | r; e.pulse = ~m_prev[1] & ab[1];
        e.dir = m_dir; e.pos = m_pos; e.qe = m_qe;
        if (e.step || e.pulse) exp_q.push_back(e);
        m_prev = ab;
    endtask

    task automatic set_ab(input logic [1:0] ab);
        @(posedge clock); #1;
        enc_a = ab[1];
        enc_b = ab[0];
        push_event(cyc + LAT, ab);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".pulse_out"}, 64'(pulse_out), 64'd0);
        check({tag, ".step"}, 64'(step), 64'd0);
        check({tag, ".direction"}, 64'(direction), 64'd0);
        check({tag, ".position"}, 64'(position), 64'd0);
        check({tag, ".quad_error"}, 64'(quad_error), 64'd0);
    endtask

    always @(negedge clock) begin
        if (!system_reset && (step || pulse_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {31'd0, step, pulse_out, position}, 64'd0);
            end else begin
                event_t e;
                e = exp_q.pop_front();
                check("event.cycle", 64'(cyc), 64'(e.cyc));
                check("event.step", 64'(step), 64'(e.step));
                check("event.pulse_out", 64'(pulse_out), 64'(e.pulse));
                check("event.direction", 64'(direction), 64'(e.dir));
                check("event.position", 64'(position), 64'(e.pos));
                check("event.quad_error", 64'(quad_error), 64'(e.qe));
            end
        end
    end

    initial begin
        #1 system_reset = 1'b1;
        #1 check_outputs_zero("reset_async");
        idle(3);
        #1 system_reset = 1'b0;
        idle(2);
        check_outputs_zero("after_reset");

        // Single reverse step from zero wraps to all ones, then back to zero
        set_ab(2'b01);
        idle(9);
        set_ab(2'b00);
        idle(9);

        for (int c = 0; c < 8; c++) begin
            set_ab(2'b10); idle(9);
            set_ab(2'b11); idle(9);
            set_ab(2'b01); idle(9);
            set_ab(2'b00); idle(9);
        end
        idle(10);
        check("fwd.position", 64'(position), 64'd32);
        check("fwd.direction", 64'(direction), 64'd1);

        // Three-cycle glitch on A is swallowed
        @(posedge clock); #1 enc_a = 1'b1;
        idle(3); #1 enc_a = 1'b0;
        idle(20);
        check("glitch3.position", 64'(position), 64'd32);

        // Four-cycle pulse survives: rise then fall after debounce
        @(posedge clock); #1 enc_a = 1'b1;
        push_event(cyc + LAT, 2'b10);
        idle(4); #1 enc_a = 1'b0;
        push_event(cyc + LAT, 2'b00);
        idle(20);

        // Illegal 00->11 with error_clear on the error cycle
        set_ab(2'b11);
        idle(LAT - 1); #1 error_clear = 1'b1;
        @(posedge clock); #1 error_clear = 1'b0;
        idle(5);
        check("illegal.quad_error_held", 64'(quad_error), 64'd1);
        check("illegal.position", 64'(position), 64'd32);
        @(posedge clock); #1 error_clear = 1'b1;
        @(posedge clock); #1 error_clear = 1'b0;
        m_qe = 1'b0;
        check("error_clear.quad_error", 64'(quad_error), 64'd0);

        set_ab(2'b01); idle(9);
        set_ab(2'b00); idle(12);
        check("pre_reset.position", 64'(position), 64'd34);

        // Reset in the middle of a pending debounce
        @(posedge clock); #1 enc_a = 1'b1;
        idle(3); #3 system_reset = 1'b1;
        #1 check_outputs_zero("midcount_reset");
        enc_a = 1'b0;
        idle(2); #1 system_reset = 1'b0;
        m_prev = 2'b00; m_pos = '0; m_dir = 1'b0; m_qe = 1'b0;
        idle(30);
        check_outputs_zero("post_reset_idle");

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
